// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write-port controller.
// Widths default to the 32x32 register file's geometry.
package regfile_ctrl_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } ctrl_state_t;

    // A limit of 2 still needs a 1-bit counter.
    function automatic int starveWidth(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Clear sequencer: walks an address counter from 0 to NREGS-1 once after reset
// and then raises a registered done flag.
module regfile_init_seq
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = 2 ** ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] o_cnt,
    output logic              o_last,
    output logic              o_done
);

    logic [ADDR_W-1:0] r_cnt;
    logic              r_done;
    logic              w_last;

    assign w_last = !r_done && (r_cnt == ADDR_W'(NREGS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            if (w_last) begin
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;
    assign o_done = r_done;

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-port sequencer/arbiter for the register file: clears all registers after
// reset, then shares the port between core writeback and a valid/ready debug port.
module regfile_write_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter int                NREGS        = 2 ** ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
    parameter int                STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_a3,
    input  logic [DATA_W-1:0] cpu_wd3,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              init_done,
    output logic              stall_req
);

    localparam int SW = starveWidth(STARVE_LIMIT);

    ctrl_state_t       r_state;
    logic [SW-1:0]     r_starve_cnt;
    logic              r_stall_req;

    logic [ADDR_W-1:0] w_init_cnt;
    logic              w_init_last;
    logic              w_init_done;
    logic              w_dbg_blocked;

    regfile_init_seq #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_init_seq (
        .clk    (clk),
        .reset  (reset),
        .o_cnt  (w_init_cnt),
        .o_last (w_init_last),
        .o_done (w_init_done)
    );

    assign w_dbg_blocked = cpu_we && dbg_valid;

    // STALL always lasts one cycle: either the debug write lands or the
    // requester dropped valid, and in both cases the core gets the port back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_starve_cnt <= '0;
                    r_stall_req  <= 1'b0;
                    if (w_init_last) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_dbg_blocked) begin
                        if (r_starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                            r_state      <= ST_STALL;
                            r_stall_req  <= 1'b1;
                            r_starve_cnt <= '0;
                        end else begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                ST_STALL: begin
                    r_state      <= ST_RUN;
                    r_stall_req  <= 1'b0;
                    r_starve_cnt <= '0;
                end
                default: begin
                    r_state      <= ST_INIT;
                    r_starve_cnt <= '0;
                    r_stall_req  <= 1'b0;
                end
            endcase
        end
    end

    // Register 0 is hard-wired zero, so outside the clear sequence any write
    // aimed at it is suppressed while a debug handshake still completes.
    always_comb begin
        rf_we     = 1'b0;
        rf_a3     = dbg_addr;
        rf_wd3    = dbg_data;
        dbg_ready = 1'b0;
        case (r_state)
            ST_INIT: begin
                rf_we  = 1'b1;
                rf_a3  = w_init_cnt;
                rf_wd3 = INIT_VALUE;
            end
            ST_RUN: begin
                if (cpu_we) begin
                    rf_we  = (cpu_a3 != '0);
                    rf_a3  = cpu_a3;
                    rf_wd3 = cpu_wd3;
                end else begin
                    dbg_ready = 1'b1;
                    rf_we     = dbg_valid && (dbg_addr != '0);
                end
            end
            ST_STALL: begin
                dbg_ready = 1'b1;
                rf_we     = dbg_valid && (dbg_addr != '0);
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
        if (reset) begin
            rf_we     = 1'b0;
            dbg_ready = 1'b0;
        end
    end

    assign init_done = w_init_done;
    assign stall_req = r_stall_req;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Self-checking bench for regfile_write_ctrl: scenario tasks plus a randomized
// run, all compared against a behavioural model of the write-port rules.
module tb_regfile_write_ctrl;

    localparam int NREGS = 32;
    localparam int LIMIT = 8;

    logic        clock;
    logic        reset;
    logic        cpuWe;
    logic [4:0]  cpuA3;
    logic [31:0] cpuWd3;
    logic        dbgValid;
    logic [4:0]  dbgAddr;
    logic [31:0] dbgData;
    logic        dbgReady;
    logic        rfWe;
    logic [4:0]  rfA3;
    logic [31:0] rfWd3;
    logic        initDone;
    logic        stallReq;

    int checks = 0;
    int errors = 0;

    // Behavioural model: remaining clear writes, consecutive blocked debug
    // cycles, and whether the core is currently being held off.
    int          mInitLeft;
    int          mBlocked;
    bit          mStall;
    logic [31:0] expRegs [NREGS];
    logic [31:0] rfMem   [NREGS];

    logic        eWe;
    logic        eReady;
    logic        eInitDone;
    logic        eStall;
    logic [4:0]  eA3;
    logic [31:0] eWd;

    regfile_write_ctrl dut (
        .clk       (clock),
        .reset     (reset),
        .cpu_we    (cpuWe),
        .cpu_a3    (cpuA3),
        .cpu_wd3   (cpuWd3),
        .dbg_valid (dbgValid),
        .dbg_addr  (dbgAddr),
        .dbg_data  (dbgData),
        .dbg_ready (dbgReady),
        .rf_we     (rfWe),
        .rf_a3     (rfA3),
        .rf_wd3    (rfWd3),
        .init_done (initDone),
        .stall_req (stallReq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in register file fed only by the DUT's write port.
    always @(posedge clock) begin
        if (rfWe) rfMem[rfA3] <= rfWd3;
    end

    task automatic modelReset();
        mInitLeft = NREGS;
        mBlocked  = 0;
        mStall    = 0;
    endtask

    task automatic predict();
        eWe = 0; eReady = 0; eA3 = 0; eWd = 0;
        eInitDone = (mInitLeft == 0);
        eStall    = mStall;
        if (reset) begin
            eInitDone = 0;
            eStall    = 0;
        end else if (mInitLeft > 0) begin
            eWe = 1; eA3 = 5'(NREGS - mInitLeft); eWd = 0;
        end else if (mStall || !cpuWe) begin
            eReady = 1;
            eWe    = dbgValid && (dbgAddr != 0);
            eA3    = dbgAddr; eWd = dbgData;
        end else begin
            eWe = (cpuA3 != 0); eA3 = cpuA3; eWd = cpuWd3;
        end
    endtask

    task automatic modelEdge();
        if (mInitLeft > 0) begin
            expRegs[NREGS - mInitLeft] = 0;
            mInitLeft--;
        end else if (mStall) begin
            if (dbgValid && dbgAddr != 0) expRegs[dbgAddr] = dbgData;
            mStall   = 0;
            mBlocked = 0;
        end else if (cpuWe) begin
            if (cpuA3 != 0) expRegs[cpuA3] = cpuWd3;
            if (dbgValid) begin
                mBlocked++;
                if (mBlocked == LIMIT) begin
                    mStall   = 1;
                    mBlocked = 0;
                end
            end else begin
                mBlocked = 0;
            end
        end else begin
            if (dbgValid && dbgAddr != 0) expRegs[dbgAddr] = dbgData;
            mBlocked = 0;
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        if (!reset) modelEdge();
        @(negedge clock);
    endtask

    task automatic applyIdle();
        cpuWe = 0; cpuA3 = 0; cpuWd3 = 0;
        dbgValid = 0; dbgAddr = 0; dbgData = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        applyIdle();
        modelReset();
        repeat (2) @(negedge clock);
        #1;
        checks++; if (rfWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b exp 0", rfWe); end
        checks++; if (dbgReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b exp 0", dbgReady); end
        checks++; if (initDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done got %b exp 0", initDone); end
        checks++; if (stallReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b exp 0", stallReq); end
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_init_clear();
        for (int i = 0; i < NREGS; i++) begin
            cpuWe = 1'($urandom); cpuA3 = 5'($urandom); cpuWd3 = $urandom;
            #1;
            checks++; if (rfWe !== 1'b1) begin errors++; $display("[TB] FAIL init_we cyc %0d got %b exp 1", i, rfWe); end
            checks++; if (rfA3 !== 5'(i)) begin errors++; $display("[TB] FAIL init_a3 cyc %0d got %0d exp %0d", i, rfA3, i); end
            checks++; if (rfWd3 !== 32'd0) begin errors++; $display("[TB] FAIL init_wd3 cyc %0d got %h exp 0", i, rfWd3); end
            checks++; if (dbgReady !== 1'b0) begin errors++; $display("[TB] FAIL init_ready cyc %0d got %b exp 0", i, dbgReady); end
            checks++; if (initDone !== 1'b0) begin errors++; $display("[TB] FAIL init_done_early cyc %0d got %b exp 0", i, initDone); end
            stepCycle();
        end
        applyIdle();
        #1;
        checks++; if (initDone !== 1'b1) begin errors++; $display("[TB] FAIL init_done got %b exp 1", initDone); end
        checks++; if (rfWe !== 1'b0) begin errors++; $display("[TB] FAIL post_init_we got %b exp 0", rfWe); end
        for (int r = 0; r < NREGS; r++) begin
            checks++; if (rfMem[r] !== 32'd0) begin errors++; $display("[TB] FAIL init_reg%0d got %h exp 0", r, rfMem[r]); end
        end
    endtask

    task automatic test_core_write();
        cpuWe = 1; cpuA3 = 31; cpuWd3 = 32'd5890;
        #1;
        checks++; if (rfWe !== 1'b1 || rfA3 !== 5'd31 || rfWd3 !== 32'd5890) begin
            errors++; $display("[TB] FAIL core_write got we=%b a3=%0d wd=%0d exp we=1 a3=31 wd=5890", rfWe, rfA3, rfWd3);
        end
        stepCycle();
        applyIdle();
        #1;
        checks++; if (rfMem[31] !== 32'd5890) begin errors++; $display("[TB] FAIL core_reg31 got %0d exp 5890", rfMem[31]); end
    endtask

    task automatic test_collision();
        logic [31:0] coreData;
        coreData = $urandom | 32'h1;
        cpuWe = 1; cpuA3 = 5; cpuWd3 = coreData;
        dbgValid = 1; dbgAddr = 5; dbgData = 32'hAA;
        #1;
        checks++; if (dbgReady !== 1'b0) begin errors++; $display("[TB] FAIL collide_ready got %b exp 0", dbgReady); end
        checks++; if (rfWe !== 1'b1 || rfWd3 !== coreData) begin
            errors++; $display("[TB] FAIL collide_core got we=%b wd=%h exp we=1 wd=%h", rfWe, rfWd3, coreData);
        end
        stepCycle();
        checks++; if (rfMem[5] !== coreData) begin errors++; $display("[TB] FAIL collide_reg5_core got %h exp %h", rfMem[5], coreData); end
        cpuWe = 0;
        #1;
        checks++; if (dbgReady !== 1'b1 || rfWe !== 1'b1 || rfA3 !== 5'd5 || rfWd3 !== 32'hAA) begin
            errors++; $display("[TB] FAIL collide_dbg got rdy=%b we=%b a3=%0d wd=%h exp rdy=1 we=1 a3=5 wd=aa", dbgReady, rfWe, rfA3, rfWd3);
        end
        stepCycle();
        applyIdle();
        #1;
        checks++; if (rfMem[5] !== 32'hAA) begin errors++; $display("[TB] FAIL collide_reg5 got %h exp aa", rfMem[5]); end
    endtask

    task automatic test_zero_addr();
        dbgValid = 1; dbgAddr = 0; dbgData = 32'h1234;
        #1;
        checks++; if (dbgReady !== 1'b1 || rfWe !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_dbg got rdy=%b we=%b exp rdy=1 we=0", dbgReady, rfWe);
        end
        stepCycle();
        applyIdle();
        cpuWe = 1; cpuA3 = 0; cpuWd3 = 32'hDEAD;
        #1;
        checks++; if (rfWe !== 1'b0) begin errors++; $display("[TB] FAIL zero_core_we got %b exp 0", rfWe); end
        stepCycle();
        applyIdle();
        #1;
        checks++; if (rfMem[0] !== 32'd0) begin errors++; $display("[TB] FAIL zero_reg0 got %h exp 0", rfMem[0]); end
    endtask

    task automatic test_starvation();
        bit hsSeen;
        hsSeen = 0;
        dbgValid = 1; dbgAddr = 9; dbgData = 32'h5A5A;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cpuWe = 1; cpuA3 = 5'($urandom_range(10, 31)); cpuWd3 = $urandom;
            #1;
            predict();
            checks++; if (stallReq !== ((cyc == 8) ? 1'b1 : 1'b0)) begin
                errors++; $display("[TB] FAIL starve_stall cyc %0d got %b exp %b", cyc, stallReq, (cyc == 8));
            end
            checks++; if (dbgReady !== eReady) begin errors++; $display("[TB] FAIL starve_ready cyc %0d got %b exp %b", cyc, dbgReady, eReady); end
            if (cyc == 8) begin
                checks++; if (rfWe !== 1'b1 || rfA3 !== 5'd9 || rfWd3 !== 32'h5A5A) begin
                    errors++; $display("[TB] FAIL starve_dbg_write got we=%b a3=%0d wd=%h exp we=1 a3=9 wd=5a5a", rfWe, rfA3, rfWd3);
                end
            end
            if (dbgValid && eReady) begin
                hsSeen = 1;
                stepCycle();
                dbgValid = 0;
            end else begin
                stepCycle();
            end
        end
        applyIdle();
        #1;
        checks++; if (!hsSeen) begin errors++; $display("[TB] FAIL starve_timeout got no handshake exp handshake within 10 cycles"); end
        checks++; if (rfMem[9] !== 32'h5A5A) begin errors++; $display("[TB] FAIL starve_reg9 got %h exp 5a5a", rfMem[9]); end
    endtask

    task automatic test_random();
        bit hs;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cpuWe  = ($urandom_range(0, 9) < 7);
            cpuA3  = 5'($urandom);
            cpuWd3 = $urandom;
            if (!dbgValid && $urandom_range(0, 2) == 0) begin
                dbgValid = 1;
                dbgAddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                dbgData  = $urandom;
            end
            #1;
            predict();
            checks++; if (rfWe !== eWe) begin errors++; $display("[TB] FAIL rand_we cyc %0d got %b exp %b", cyc, rfWe, eWe); end
            checks++; if (dbgReady !== eReady) begin errors++; $display("[TB] FAIL rand_ready cyc %0d got %b exp %b", cyc, dbgReady, eReady); end
            checks++; if (stallReq !== eStall) begin errors++; $display("[TB] FAIL rand_stall cyc %0d got %b exp %b", cyc, stallReq, eStall); end
            if (eWe) begin
                checks++; if (rfA3 !== eA3 || rfWd3 !== eWd) begin
                    errors++; $display("[TB] FAIL rand_port cyc %0d got a3=%0d wd=%h exp a3=%0d wd=%h", cyc, rfA3, rfWd3, eA3, eWd);
                end
            end
            hs = dbgValid && eReady;
            stepCycle();
            if (hs) dbgValid = 0;
        end
        applyIdle();
        #1;
        for (int r = 0; r < NREGS; r++) begin
            checks++; if (rfMem[r] !== expRegs[r]) begin errors++; $display("[TB] FAIL rand_reg%0d got %h exp %h", r, rfMem[r], expRegs[r]); end
        end
    endtask

    task automatic test_reset_mid_init();
        reset = 1;
        applyIdle();
        modelReset();
        @(negedge clock);
        reset = 0;
        repeat (10) stepCycle();
        #2;
        reset = 1;
        modelReset();
        #1;
        checks++; if (rfWe !== 1'b0) begin errors++; $display("[TB] FAIL midreset_we got %b exp 0", rfWe); end
        checks++; if (initDone !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b exp 0", initDone); end
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < NREGS; i++) begin
            #1;
            checks++; if (rfWe !== 1'b1 || rfA3 !== 5'(i)) begin
                errors++; $display("[TB] FAIL reinit_seq cyc %0d got we=%b a3=%0d exp we=1 a3=%0d", i, rfWe, rfA3, i);
            end
            stepCycle();
        end
        #1;
        checks++; if (initDone !== 1'b1) begin errors++; $display("[TB] FAIL reinit_done got %b exp 1", initDone); end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_core_write();
        test_collision();
        test_zero_addr();
        test_starvation();
        test_random();
        test_reset_mid_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
